// File: rtl/round_pkg.sv
// round_pkg: codes shared between the duel referee (round_judge) and the game controller.
//   - controller STATE_IN codes
//   - JUDG / WRONG / HP_OUT output codes
//   - referee FSM state type and the answer-check helper
//   - default clock frequency
package round_pkg;

    localparam int unsigned DefClkHz = 50_000_000;

    // Controller state codes
    localparam logic [3:0] CtlReady    = 4'b0010;
    localparam logic [3:0] CtlQuestion = 4'b0011;
    localparam logic [3:0] CtlInput    = 4'b0100;
    localparam logic [3:0] CtlDraw     = 4'b0110;
    localparam logic [3:0] CtlWrong    = 4'b0111;
    localparam logic [3:0] CtlGood     = 4'b1000;
    localparam logic [3:0] CtlOuch     = 4'b1001;
    localparam logic [3:0] CtlWin      = 4'b1010;
    localparam logic [3:0] CtlLose     = 4'b1011;

    // Verdict codes
    localparam logic [1:0] JudgNone  = 2'b00;
    localparam logic [1:0] JudgP1    = 2'b01;
    localparam logic [1:0] JudgP2    = 2'b10;
    localparam logic [1:0] JudgDraw  = 2'b11;
    localparam logic [1:0] WrongNone = 2'b00;
    localparam logic [1:0] WrongBad  = 2'b11;
    localparam logic [1:0] HpAlive   = 2'b00;
    localparam logic [1:0] HpP2Zero  = 2'b01;
    localparam logic [1:0] HpP1Zero  = 2'b10;

    typedef enum logic [1:0] {StIdle, StArmed, StCheck, StHold} judge_state_e;

    // Trivial factorizations (factor 0 or 1) never count as an answer.
    function automatic logic answer_ok(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                       input logic [15:0] prod, input logic [15:0] q);
        return sub && (a > 8'd1) && (b > 8'd1) && (prod == q);
    endfunction

endpackage

// File: rtl/round_judge_if.sv
// round_judge_if: bundle between the game controller / players and the referee.
//   inputs to referee : state_in[3:0], q_val[15:0], p1_sub, p2_sub, p1_a/p1_b/p2_a/p2_b[7:0]
//   outputs of referee: judg_out[1:0], wrong_out[1:0], hp_out[1:0], hp1/hp2[2:0],
//                       time_left[4:0], busy
// Modports: master = controller/player side, slave = referee.
interface round_judge_if;

    logic [3:0]  state_in;
    logic [15:0] q_val;
    logic        p1_sub;
    logic        p2_sub;
    logic [7:0]  p1_a;
    logic [7:0]  p1_b;
    logic [7:0]  p2_a;
    logic [7:0]  p2_b;
    logic [1:0]  judg_out;
    logic [1:0]  wrong_out;
    logic [1:0]  hp_out;
    logic [2:0]  hp1;
    logic [2:0]  hp2;
    logic [4:0]  time_left;
    logic        busy;

    modport master (
        output state_in, q_val, p1_sub, p2_sub, p1_a, p1_b, p2_a, p2_b,
        input  judg_out, wrong_out, hp_out, hp1, hp2, time_left, busy
    );

    modport slave (
        input  state_in, q_val, p1_sub, p2_sub, p1_a, p1_b, p2_a, p2_b,
        output judg_out, wrong_out, hp_out, hp1, hp2, time_left, busy
    );

endinterface

// File: rtl/sec_tick.sv
// sec_tick: one-second strobe generator.
//   clk  - clock
//   rst  - synchronous active-high reset
//   en   - count enable; the counter holds its value while low
//   clr  - synchronous clear of the counter (wins over en)
//   tick - one-cycle strobe on the enabled cycle that ends each CLK_HZ-cycle period
module sec_tick #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = en && (cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/round_judge.sv
// round_judge: referee for the factorization duel. Judges the first valid factor pair, keeps
// both HP counters and runs the per-round answer timer.
//   clk, rst - clock, synchronous active-high reset
//   bus      - round_judge_if.slave (controller state, question, submissions, verdict outputs)
// Optional feature macro: ROUND_JUDGE_LOCKOUT_EN (a player who caused WRONG is locked out for
// the rest of the round; both locked gives a draw).
module round_judge
    import round_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DefClkHz,
    parameter int unsigned TIME_LIMIT = 20,
    parameter int unsigned HP_INIT    = 3
) (
    input logic          clk,
    input logic          rst,
    round_judge_if.slave bus
);

    localparam logic [4:0] TimeInit = 5'(TIME_LIMIT);
    localparam logic [2:0] HpInit   = 3'(HP_INIT);

    judge_state_e state_q, state_d;
    logic         phase_q, phase_d;  // 0: product cycle, 1: verdict cycle
    logic         sub1_q, sub1_d, sub2_q, sub2_d;
    logic [7:0]   a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
    logic [15:0]  prod1_q, prod1_d, prod2_q, prod2_d;
    logic [1:0]   judg_q, judg_d, wrong_q, wrong_d, hp_out_q, hp_out_d;
    logic [2:0]   hp1_q, hp1_d, hp2_q, hp2_d;
    logic [4:0]   time_q, time_d;
    logic [3:0]   ctl_prev_q;

    logic       in_input, reload_timer, reload_hp, tick_en, sec;
    logic       ok1, ok2, lock1, lock2, go1, go2;
    logic [2:0] hp1_dec, hp2_dec;

    assign in_input     = (bus.state_in == CtlInput);
    assign reload_timer = (ctl_prev_q == CtlQuestion) && in_input;
    assign reload_hp    = ((ctl_prev_q == CtlWin) || (ctl_prev_q == CtlLose)) &&
                          (bus.state_in == CtlReady);
    assign tick_en      = (state_q == StArmed) && in_input;

    sec_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .clr (reload_timer),
        .tick(sec)
    );

    assign ok1     = answer_ok(sub1_q, a1_q, b1_q, prod1_q, bus.q_val);
    assign ok2     = answer_ok(sub2_q, a2_q, b2_q, prod2_q, bus.q_val);
    assign hp1_dec = (hp1_q != 3'd0) ? hp1_q - 3'd1 : 3'd0;
    assign hp2_dec = (hp2_q != 3'd0) ? hp2_q - 3'd1 : 3'd0;
    assign go1     = bus.p1_sub && !lock1;
    assign go2     = bus.p2_sub && !lock2;

`ifdef ROUND_JUDGE_LOCKOUT_EN
    logic wrong_set;
    assign wrong_set = (state_q == StCheck) && phase_q && !ok1 && !ok2;

    always_ff @(posedge clk) begin
        if (rst || reload_timer) begin
            lock1 <= 1'b0;
            lock2 <= 1'b0;
        end else if (wrong_set) begin
            lock1 <= lock1 | sub1_q;
            lock2 <= lock2 | sub2_q;
        end
    end
`else
    assign lock1 = 1'b0;
    assign lock2 = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        sub1_d   = sub1_q;
        sub2_d   = sub2_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        a2_d     = a2_q;
        b2_d     = b2_q;
        prod1_d  = prod1_q;
        prod2_d  = prod2_q;
        judg_d   = judg_q;
        wrong_d  = wrong_q;
        hp_out_d = hp_out_q;
        hp1_d    = hp1_q;
        hp2_d    = hp2_q;
        time_d   = time_q;

        // sec only fires in ARMED with the controller in INPUT
        if (sec && (time_q != 5'd0)) begin
            time_d = time_q - 5'd1;
        end

        case (state_q)
            StIdle: begin
                if (in_input) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (lock1 && lock2) begin
                    judg_d  = JudgDraw;
                    state_d = StHold;
                end else if (go1 || go2) begin
                    // A submit beats a same-cycle timeout.
                    sub1_d  = go1;
                    sub2_d  = go2;
                    a1_d    = bus.p1_a;
                    b1_d    = bus.p1_b;
                    a2_d    = bus.p2_a;
                    b2_d    = bus.p2_b;
                    phase_d = 1'b0;
                    state_d = StCheck;
                end else if (sec && (time_q == 5'd0)) begin
                    judg_d  = JudgDraw;
                    state_d = StHold;
                end
            end
            StCheck: begin
                if (!phase_q) begin
                    prod1_d = 16'(a1_q) * 16'(b1_q);
                    prod2_d = 16'(a2_q) * 16'(b2_q);
                    phase_d = 1'b1;
                end else begin
                    state_d = StHold;
                    if (ok1 && ok2) begin
                        judg_d = JudgDraw;
                    end else if (ok1) begin
                        judg_d = JudgP1;
                        hp2_d  = hp2_dec;
                        if ((hp2_dec == 3'd0) && (hp_out_q == HpAlive)) begin
                            hp_out_d = HpP2Zero;
                        end
                    end else if (ok2) begin
                        judg_d = JudgP2;
                        hp1_d  = hp1_dec;
                        if ((hp1_dec == 3'd0) && (hp_out_q == HpAlive)) begin
                            hp_out_d = HpP1Zero;
                        end
                    end else begin
                        wrong_d = WrongBad;
                    end
                end
            end
            StHold: begin
                // Leaving INPUT means the controller consumed the verdict. Both JUDG and WRONG
                // go back to IDLE; IDLE re-arms on INPUT without touching the timer, so a WRONG
                // round resumes where it paused.
                if (!in_input) begin
                    judg_d  = JudgNone;
                    wrong_d = WrongNone;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (reload_timer) begin
            time_d = TimeInit;
        end
        if (reload_hp) begin
            hp1_d    = HpInit;
            hp2_d    = HpInit;
            hp_out_d = HpAlive;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            sub1_q     <= 1'b0;
            sub2_q     <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            a2_q       <= '0;
            b2_q       <= '0;
            prod1_q    <= '0;
            prod2_q    <= '0;
            judg_q     <= JudgNone;
            wrong_q    <= WrongNone;
            hp_out_q   <= HpAlive;
            hp1_q      <= HpInit;
            hp2_q      <= HpInit;
            time_q     <= TimeInit;
            ctl_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            sub1_q     <= sub1_d;
            sub2_q     <= sub2_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            a2_q       <= a2_d;
            b2_q       <= b2_d;
            prod1_q    <= prod1_d;
            prod2_q    <= prod2_d;
            judg_q     <= judg_d;
            wrong_q    <= wrong_d;
            hp_out_q   <= hp_out_d;
            hp1_q      <= hp1_d;
            hp2_q      <= hp2_d;
            time_q     <= time_d;
            ctl_prev_q <= bus.state_in;
        end
    end

    assign bus.judg_out  = judg_q;
    assign bus.wrong_out = wrong_q;
    assign bus.hp_out    = hp_out_q;
    assign bus.hp1       = hp1_q;
    assign bus.hp2       = hp2_q;
    assign bus.time_left = time_q;
    assign bus.busy      = (state_q == StCheck) || (state_q == StHold);

endmodule
